// File: rtl/prach_fft_pkg.sv
// ---------------------------------------------------------------------------
// prach_fft_pkg
// Shared types for the PRACH FFT front end.
//   SampleWidth   : width of one real or imaginary sample component
//   sample_t      : signed sample component
//   frame_state_e : frame sequencer states
// ---------------------------------------------------------------------------
package prach_fft_pkg;

    localparam int SampleWidth = 18;

    typedef logic signed [SampleWidth-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } frame_state_e;

endpackage

// File: rtl/delay.sv
// ---------------------------------------------------------------------------
// delay
// Generic fixed-latency pipeline delay.
//   clk   : clock
//   rst_n : asynchronous active-low reset (tie high for pure data paths)
//   din   : input word, WIDTH bits
//   dout  : din delayed by DELAY clock cycles (DELAY >= 1)
// ---------------------------------------------------------------------------
module delay #(
    parameter int WIDTH = 36,
    parameter int DELAY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DELAY-1:0][WIDTH-1:0] pipe;

    // Plain shift chain: stage 0 takes the input, every later stage takes
    // its predecessor, and the last stage is the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DELAY-1];

endmodule

// File: rtl/prach_ctrl_dly.sv
// ---------------------------------------------------------------------------
// prach_ctrl_dly
// Resettable shift register for framing control bits. All intermediate
// stages are exposed so the owner can see whether anything is in flight.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   din    : control word in, WIDTH bits
//   dout   : din delayed by DELAY cycles (DELAY >= 1)
//   stages : contents of all DELAY stages, stage DELAY-1 equals dout
// ---------------------------------------------------------------------------
module prach_ctrl_dly #(
    parameter int WIDTH = 2,
    parameter int DELAY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [DELAY-1:0][WIDTH-1:0] stages
);

    // Control bits must never carry stale values out of reset, so unlike
    // the data path every stage here is cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DELAY-1];

endmodule

// File: rtl/prach_fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// prach_fft_frame_ctrl
// Frame sequencer in front of the PRACH radix-2 DIT butterfly chain.
// Checks frame length, gates out samples that arrive outside a frame and
// produces the main and early (ahead) framing strobes for the butterflies.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_dr, s_di        : input sample (signed real / imaginary)
//   s_dv, s_sop       : input valid, start of frame (qualified by s_dv)
//   dout_dr, dout_di  : sample to the first butterfly, 1+AHEAD cycles late
//   dout_dv, sync_out : gated valid and frame sync, 1+AHEAD cycles late
//   dout_dv_ahead,
//   sync_ahead_out    : gated valid and sync, 1 cycle late
//   err_short         : pulse when a frame is cut short by a new s_sop
//   err_orphan        : pulse per valid sample dropped outside a frame
//   frame_cnt         : completed frame count, wraps
//   busy              : frame in progress or valid sample still in flight
// ---------------------------------------------------------------------------
module prach_fft_frame_ctrl
    import prach_fft_pkg::*;
#(
    parameter int NUM_FFT_LENGTH = 6,
    parameter int AHEAD          = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [SampleWidth-1:0] s_dr,
    input  logic signed [SampleWidth-1:0] s_di,
    input  logic                          s_dv,
    input  logic                          s_sop,
    output logic signed [SampleWidth-1:0] dout_dr,
    output logic signed [SampleWidth-1:0] dout_di,
    output logic                          dout_dv,
    output logic                          sync_out,
    output logic                          dout_dv_ahead,
    output logic                          sync_ahead_out,
    output logic                          err_short,
    output logic                          err_orphan,
    output logic [15:0]                   frame_cnt,
    output logic                          busy
);

    localparam int IdxWidth = $clog2(NUM_FFT_LENGTH + 1);
    localparam logic [IdxWidth-1:0] LastIdxM1 = IdxWidth'(NUM_FFT_LENGTH - 1);

    frame_state_e            state;
    logic [IdxWidth-1:0]     idx;
    logic                    gate_dv;
    logic                    gate_sync;
    logic                    in_dv_q;
    logic                    in_sync_q;
    logic [2*SampleWidth-1:0] in_data_q;
    logic [2*SampleWidth-1:0] dly_data;
    logic [1:0]              dly_ctrl;
    logic [AHEAD-1:0][1:0]   ctrl_stages;

    // Gating decision for the current input. A start marker is always
    // accepted (as a fresh start or as a restart); a plain sample only
    // while a frame is running.
    always_comb begin
        gate_dv   = 1'b0;
        gate_sync = 1'b0;
        if (s_dv) begin
            if (s_sop) begin
                gate_dv   = 1'b1;
                gate_sync = 1'b1;
            end else if (state == RUN) begin
                gate_dv = 1'b1;
            end
        end
    end

    // Frame sequencer with its registered status outputs. The sample that
    // completes a frame returns the machine to IDLE, so a start marker on
    // the very next valid sample begins a new frame with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            frame_cnt  <= '0;
            err_short  <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            err_short  <= s_dv & s_sop & (state == RUN);
            err_orphan <= s_dv & ~s_sop & (state == IDLE);
            if (s_dv) begin
                case (state)
                    IDLE: begin
                        if (s_sop) begin
                            idx   <= IdxWidth'(1);
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (s_sop) begin
                            idx <= IdxWidth'(1);
                        end else if (idx == LastIdxM1) begin
                            idx       <= '0;
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

    // Input register for the gated control bits. Both the ahead and the
    // main strobes come from these two flops, so they cannot disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_dv_q   <= 1'b0;
            in_sync_q <= 1'b0;
        end else begin
            in_dv_q   <= gate_dv;
            in_sync_q <= gate_sync;
        end
    end

    // Input register for the sample itself; data is don't-care whenever
    // the matching valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        in_data_q <= {s_dr, s_di};
    end

    assign dout_dv_ahead  = in_dv_q;
    assign sync_ahead_out = in_sync_q;

    prach_ctrl_dly #(
        .WIDTH (2),
        .DELAY (AHEAD)
    ) u_ctrl_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    ({in_sync_q, in_dv_q}),
        .dout   (dly_ctrl),
        .stages (ctrl_stages)
    );

    delay #(
        .WIDTH (2 * SampleWidth),
        .DELAY (AHEAD)
    ) u_data_dly (
        .clk   (clk),
        .rst_n (1'b1),
        .din   (in_data_q),
        .dout  (dly_data)
    );

    assign dout_dv  = dly_ctrl[0];
    assign sync_out = dly_ctrl[1];

    // The unreset data path is masked with the valid so the sample outputs
    // read zero during and right after reset instead of leaking old data.
    assign dout_dr = dout_dv ? dly_data[2*SampleWidth-1:SampleWidth] : '0;
    assign dout_di = dout_dv ? dly_data[SampleWidth-1:0] : '0;

    // A sync bit is only ever set together with its valid bit, so OR-ing
    // every bit of every control stage is the same as OR-ing the valids.
    assign busy = (state == RUN) | in_dv_q | (|ctrl_stages);

endmodule
